// File: rtl/sd_sector_reader.sv
// Single-block read sequencer for sd_controller: issues the read, captures the
// streamed sector into a local buffer and exposes it through a registered read port.
//   state      | meaning
//   IDLE       | waiting for start; status outputs hold result of last read
//   WAIT_READY | waiting for the controller to be ready for a command
//   ISSUE      | rd asserted until the controller drops ready
//   RECEIVE    | capturing one byte per byte_available rising edge
//   WAIT_IDLE  | sector complete, waiting for the controller to return to ready
module sd_sector_reader #(
  parameter int SECTOR_BYTES   = 512,
  parameter int ADDR_W         = 9,
  parameter int TIMEOUT_CYCLES = 25_000_000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [31:0]       sector,
  input  logic              sd_ready,
  input  logic [7:0]        sd_dout,
  input  logic              sd_byte_available,
  output logic              sd_rd,
  output logic [31:0]       sd_address,
  input  logic [ADDR_W-1:0] buf_raddr,
  output logic [7:0]        buf_rdata,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   byte_count
);

  typedef enum logic [2:0] {IDLE, WAIT_READY, ISSUE, RECEIVE, WAIT_IDLE} state_t;

  localparam logic [ADDR_W:0] FULL     = (ADDR_W+1)'(SECTOR_BYTES);
  localparam logic [ADDR_W:0] CNT_ONE  = (ADDR_W+1)'(1);
  localparam logic [31:0]     TMO_LAST = 32'(TIMEOUT_CYCLES - 1);

  state_t          state, state_d;
  logic            rd_d, done_d, error_d, cap, tmo_hit;
  logic [31:0]     addr_d, tmo_cnt, tmo_d;
  logic [ADDR_W:0] cnt_d;
  logic            bav_q;
  logic [7:0]      mem [SECTOR_BYTES];

  always_comb begin
    state_d = state;
    rd_d    = 1'b0;
    addr_d  = sd_address;
    done_d  = done;
    error_d = error;
    cnt_d   = byte_count;
    cap     = 1'b0;
    tmo_hit = (state != IDLE) && (tmo_cnt == TMO_LAST);
    if (tmo_hit) begin
      // byte_count deliberately keeps the partial count for diagnosis
      state_d = IDLE;
      error_d = 1'b1;
    end else begin
      case (state)
        IDLE: if (start) begin
          addr_d  = sector;
          done_d  = 1'b0;
          error_d = 1'b0;
          cnt_d   = '0;
          state_d = WAIT_READY;
        end
        WAIT_READY: if (sd_ready) state_d = ISSUE;
        ISSUE: begin
          if (!sd_ready) state_d = RECEIVE;
          else           rd_d    = 1'b1;
        end
        RECEIVE: if (sd_byte_available && !bav_q) begin
          cap   = 1'b1;
          cnt_d = byte_count + CNT_ONE;
          if (cnt_d == FULL) state_d = WAIT_IDLE;
        end
        WAIT_IDLE: if (sd_ready) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
    tmo_d = (state_d == IDLE || state_d != state || cap) ? '0 : tmo_cnt + 32'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      sd_rd      <= 1'b0;
      sd_address <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
      byte_count <= '0;
      tmo_cnt    <= '0;
      bav_q      <= 1'b0;
      buf_rdata  <= '0;
    end else begin
      state      <= state_d;
      sd_rd      <= rd_d;
      sd_address <= addr_d;
      busy       <= (state_d != IDLE);
      done       <= done_d;
      error      <= error_d;
      byte_count <= cnt_d;
      tmo_cnt    <= tmo_d;
      bav_q      <= sd_byte_available;
      buf_rdata  <= mem[buf_raddr];
    end
  end

  // Buffer storage is not reset; contents are undefined until written.
  always_ff @(posedge clk) begin
    if (cap) mem[byte_count[ADDR_W-1:0]] <= sd_dout;
  end

endmodule

// File: tb/tb_sd_sector_reader.sv
// Bench for sd_sector_reader: behavioural controller model driving the sd_* side,
// with expected buffer bytes queued as they are streamed and compared on read-out.
module tb_sd_sector_reader;
  localparam int SB  = 512;
  localparam int AW  = 9;
  localparam int TMO = 100;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [31:0]   sector = '0;
  logic          sd_ready = 1'b0;
  logic [7:0]    sd_dout = '0;
  logic          sd_byte_available = 1'b0;
  logic [AW-1:0] buf_raddr = '0;
  logic          sd_rd, busy, done, error;
  logic [31:0]   sd_address;
  logic [7:0]    buf_rdata;
  logic [AW:0]   byte_count;

  sd_sector_reader #(.SECTOR_BYTES(SB), .ADDR_W(AW), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset(reset), .start(start), .sector(sector),
    .sd_ready(sd_ready), .sd_dout(sd_dout), .sd_byte_available(sd_byte_available),
    .sd_rd(sd_rd), .sd_address(sd_address), .buf_raddr(buf_raddr),
    .buf_rdata(buf_rdata), .busy(busy), .done(done), .error(error),
    .byte_count(byte_count)
  );

  always #20 clk = ~clk;

  int passed = 0;
  int total = 0;
  int rd_rises = 0;
  logic rd_q = 1'b0;
  logic [7:0] exp_q[$];

  always @(negedge clk) begin
    if (sd_rd && !rd_q) rd_rises++;
    rd_q = sd_rd;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] pat(input int seed, input int i);
    return 8'(i + seed * 37);
  endfunction

  task automatic send_byte(input logic [7:0] d, input int hold, output logic [AW:0] bc);
    sd_dout = d;
    sd_byte_available = 1'b1;
    tick();
    bc = byte_count;
    repeat (hold - 1) tick();
    sd_byte_available = 1'b0;
    tick();
  endtask

  task automatic start_read(input logic [31:0] sec, output int rd0);
    rd0 = rd_rises;
    sd_ready = 1'b1;
    sector = sec;
    start = 1'b1;
    tick();
    start = 1'b0;
    sector = ~sec;
    total++; if (busy !== 1'b1) $display("FAIL start_busy: got %0b want 1", busy); else passed++;
    total++; if (sd_address !== sec) $display("FAIL start_addr: got %h want %h", sd_address, sec); else passed++;
    tick();
    total++; if (sd_rd !== 1'b0) $display("FAIL rd_early: got %0b want 0", sd_rd); else passed++;
    tick();
    total++; if (sd_rd !== 1'b1) $display("FAIL rd_rise: got %0b want 1", sd_rd); else passed++;
    tick();
    sd_ready = 1'b0;
    tick();
    total++; if (sd_rd !== 1'b0) $display("FAIL rd_fall: got %0b want 0", sd_rd); else passed++;
  endtask

  task automatic stream(input int seed, input int n, input int hold);
    logic [AW:0] bc;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(pat(seed, i));
      send_byte(pat(seed, i), hold, bc);
      total++;
      if (bc !== (AW+1)'(i + 1)) $display("FAIL byte_count_step: byte %0d got %0d want %0d", i, bc, i + 1);
      else passed++;
    end
  endtask

  task automatic finish_read(input logic [31:0] sec, input int rd0);
    sd_ready = 1'b1;
    tick();
    total++; if (done !== 1'b1) $display("FAIL done: got %0b want 1", done); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL busy_end: got %0b want 0", busy); else passed++;
    total++; if (error !== 1'b0) $display("FAIL error_end: got %0b want 0", error); else passed++;
    total++; if (byte_count !== (AW+1)'(SB)) $display("FAIL count_end: got %0d want %0d", byte_count, SB); else passed++;
    total++; if (sd_address !== sec) $display("FAIL addr_end: got %h want %h", sd_address, sec); else passed++;
    total++; if (rd_rises - rd0 !== 1) $display("FAIL rd_pulses: got %0d want 1", rd_rises - rd0); else passed++;
  endtask

  task automatic readout(input int n);
    logic [7:0] e;
    for (int i = 0; i < n; i++) begin
      buf_raddr = AW'(i);
      tick();
      e = exp_q.pop_front();
      total++;
      if (buf_rdata !== e) $display("FAIL buf_read: addr %0d got %h want %h", i, buf_rdata, e);
      else passed++;
    end
    total++; if (exp_q.size() !== 0) $display("FAIL queue_left: got %0d want 0", exp_q.size()); else passed++;
  endtask

  task automatic check_all_zero(input string tag);
    total++;
    if ({sd_rd, busy, done, error} !== 4'b0 || sd_address !== '0 || byte_count !== '0 || buf_rdata !== '0)
      $display("FAIL %s: rd=%0b busy=%0b done=%0b err=%0b addr=%h cnt=%0d rdata=%h want all 0",
               tag, sd_rd, busy, done, error, sd_address, byte_count, buf_rdata);
    else passed++;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    check_all_zero("reset_state");
    reset = 1'b0;
    tick();
  endtask

  task automatic test_normal_read();
    int rd0;
    start_read(32'h0000_0800, rd0);
    stream(0, SB, 2);
    finish_read(32'h0000_0800, rd0);
    readout(SB);
  endtask

  task automatic test_held_strobe();
    int rd0;
    start_read(32'h0000_0900, rd0);
    stream(1, SB, 5);
    finish_read(32'h0000_0900, rd0);
    readout(SB);
  endtask

  task automatic test_timeout();
    int rd0;
    start_read(32'h0000_1234, rd0);
    stream(4, 10, 1);
    repeat (TMO - 2) tick();
    total++; if (error !== 1'b0) $display("FAIL timeout_early: got %0b want 0", error); else passed++;
    tick();
    total++; if (error !== 1'b1) $display("FAIL timeout_error: got %0b want 1", error); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL timeout_busy: got %0b want 0", busy); else passed++;
    total++; if (sd_rd !== 1'b0) $display("FAIL timeout_rd: got %0b want 0", sd_rd); else passed++;
    total++; if (done !== 1'b0) $display("FAIL timeout_done: got %0b want 0", done); else passed++;
    total++; if (byte_count !== (AW+1)'(10)) $display("FAIL timeout_count: got %0d want 10", byte_count); else passed++;
    readout(10);
  endtask

  task automatic test_ignored_start();
    int rd0;
    logic [AW:0] bc;
    start_read(32'h0000_1000, rd0);
    stream(2, 50, 2);
    start = 1'b1;
    sector = 32'hDEAD_BEEF;
    tick();
    start = 1'b0;
    total++; if (sd_address !== 32'h0000_1000) $display("FAIL ignored_start_addr: got %h want 00001000", sd_address); else passed++;
    for (int i = 50; i < SB; i++) begin
      exp_q.push_back(pat(2, i));
      send_byte(pat(2, i), 2, bc);
    end
    send_byte(8'hAA, 2, bc);
    total++; if (bc !== (AW+1)'(SB)) $display("FAIL extra_strobe_count: got %0d want %0d", bc, SB); else passed++;
    finish_read(32'h0000_1000, rd0);
    readout(SB);
  endtask

  task automatic test_reset_mid_receive();
    int rd0;
    start_read(32'h0000_2000, rd0);
    stream(5, 100, 2);
    exp_q.delete();
    #7;
    reset = 1'b1;
    #1;
    check_all_zero("reset_mid_receive");
    tick();
    tick();
    check_all_zero("reset_held");
    reset = 1'b0;
    tick();
    start_read(32'h0000_3000, rd0);
    stream(3, SB, 3);
    finish_read(32'h0000_3000, rd0);
    readout(SB);
  endtask

  initial begin
    test_reset();
    test_normal_read();
    test_held_strobe();
    test_timeout();
    test_ignored_start();
    test_reset_mid_receive();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
